xg_hazard_ctrl: RTL

Parametrised hazard and forwarding controller for the xgriscv pipeline. It keeps its own shadow copy of each in-flight instruction's destination and type, from execute through writeback, over DEPTH stages. From that copy it drives stall, flush and forwarding-select outputs to the datapath's pipeline registers and operand muxes. It replaces the fixed `flush = 0` / `enable = 1` wiring and adds load-use stalling, branch-redirect flushing, E-stage forwarding, optional D-stage forwarding and saturating stall/flush counters.

---
 rtl/xg_hazard_ctrl_pkg.sv | 24 ++
 rtl/xg_hazard_ctrl_hz_slot.sv | 23 ++
 rtl/xg_hazard_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/xg_hazard_ctrl_pkg.sv
// Shared types and constants for the xgriscv hazard controller: the shadow
// slot record, its width, and the "no forward" select code.
package xg_hazard_ctrl_pkg;

   typedef struct packed {
      logic       v;
      logic       wr;
      logic       ld;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
   } slot_t;

   localparam int SLOT_W   = $bits(slot_t);
   localparam int FWD_NONE = 0;

   // A slot produces rs when it is live, writes a non-x0 register and the operand is read.
   function automatic logic slot_match(input slot_t s, input logic [4:0] rs, input logic use_f);
      return s.v & s.wr & use_f & (s.rd == rs);
   endfunction

endpackage

// File: rtl/xg_hazard_ctrl_hz_slot.sv
// One shadow pipeline slot: async-reset record register with a synchronous
// clear that inserts a bubble.
module hz_slot
   import xg_hazard_ctrl_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  i_clr,
   input  slot_t i_d,
   output slot_t o_q
);

   slot_t r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        r_q <= '0;
      else if (i_clr) r_q <= '0;
      else            r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/xg_hazard_ctrl.sv
// Hazard/forwarding controller: shadow slots E..W, load-use and branch stalls,
// redirect flush, E/D forwarding selects. XG_HAZARD_DFWD_EN enables D-stage forwarding.
module xg_hazard_ctrl
   import xg_hazard_ctrl_pkg::*;
#(
   parameter  int DEPTH      = 3,
   parameter  int LOAD_READY = 1,
   parameter  int CNT_W      = 16,
   localparam int FW         = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             validD,
   input  logic [4:0]       rs1D,
   input  logic [4:0]       rs2D,
   input  logic             use1D,
   input  logic             use2D,
   input  logic             branchD,
   input  logic [4:0]       rdD,
   input  logic             regwriteD,
   input  logic             memtoregD,
   input  logic             pcsrcD,
   output logic             stallF,
   output logic             stallD,
   output logic             flushD,
   output logic             flushE,
   output logic [FW-1:0]    fwdaE,
   output logic [FW-1:0]    fwdbE,
   output logic [FW-1:0]    fwdaD,
   output logic [FW-1:0]    fwdbD,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   slot_t             w_slot [DEPTH];
   slot_t             w_rec_d;
   logic              w_ld_stall, w_br_stall, w_stall, w_flush;
   logic [FW-1:0]     w_fa_e, w_fb_e, w_fa_d, w_fb_d;
   logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;

   always_comb begin
      w_rec_d     = '0;
      w_rec_d.v   = validD;
      w_rec_d.wr  = regwriteD & (rdD != 5'd0);
      w_rec_d.ld  = memtoregD;
      w_rec_d.rd  = rdD;
      w_rec_d.rs1 = rs1D;
      w_rec_d.rs2 = rs2D;
      w_rec_d.u1  = use1D;
      w_rec_d.u2  = use2D;
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      if (g == 0) begin : g_head
         hz_slot u_slot (
            .clk   (clk),
            .rst   (reset),
            .i_clr (~(validD & ~w_stall)),
            .i_d   (w_rec_d),
            .o_q   (w_slot[0])
         );
      end else begin : g_tail
         hz_slot u_slot (
            .clk   (clk),
            .rst   (reset),
            .i_clr (1'b0),
            .i_d   (w_slot[g-1]),
            .o_q   (w_slot[g])
         );
      end
   end

   // Loops run oldest to youngest so the youngest (lowest k) producer wins.
   always_comb begin
      w_ld_stall = 1'b0;
      w_br_stall = 1'b0;
      w_fa_e     = FW'(FWD_NONE);
      w_fb_e     = FW'(FWD_NONE);
      w_fa_d     = FW'(FWD_NONE);
      w_fb_d     = FW'(FWD_NONE);
      for (int k = DEPTH - 1; k >= 1; k--) begin
         if (slot_match(w_slot[k], w_slot[0].rs1, w_slot[0].u1))
            w_fa_e = (w_slot[k].ld && k <= LOAD_READY) ? FW'(FWD_NONE) : FW'(k);
         if (slot_match(w_slot[k], w_slot[0].rs2, w_slot[0].u2))
            w_fb_e = (w_slot[k].ld && k <= LOAD_READY) ? FW'(FWD_NONE) : FW'(k);
      end
      for (int k = 0; k < LOAD_READY && k < DEPTH; k++) begin
         if (validD && w_slot[k].ld &&
             (slot_match(w_slot[k], rs1D, use1D) || slot_match(w_slot[k], rs2D, use2D)))
            w_ld_stall = 1'b1;
      end
`ifdef XG_HAZARD_DFWD_EN
      begin
         logic w_a_hit, w_a_rdy, w_b_hit, w_b_rdy;
         logic [FW-1:0] w_a_k, w_b_k;
         w_a_hit = 1'b0; w_a_rdy = 1'b0; w_a_k = '0;
         w_b_hit = 1'b0; w_b_rdy = 1'b0; w_b_k = '0;
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (slot_match(w_slot[k], rs1D, use1D)) begin
               w_a_hit = 1'b1;
               w_a_k   = FW'(k);
               w_a_rdy = w_slot[k].ld ? (k > LOAD_READY) : (k >= 1);
            end
            if (slot_match(w_slot[k], rs2D, use2D)) begin
               w_b_hit = 1'b1;
               w_b_k   = FW'(k);
               w_b_rdy = w_slot[k].ld ? (k > LOAD_READY) : (k >= 1);
            end
         end
         if (validD && branchD) begin
            if (w_a_hit && w_a_rdy) w_fa_d = w_a_k;
            if (w_b_hit && w_b_rdy) w_fb_d = w_b_k;
            w_br_stall = (w_a_hit && !w_a_rdy) || (w_b_hit && !w_b_rdy);
         end
      end
`else
      for (int k = 0; k < DEPTH; k++) begin
         if (validD && branchD &&
             (slot_match(w_slot[k], rs1D, use1D) || slot_match(w_slot[k], rs2D, use2D)))
            w_br_stall = 1'b1;
      end
`endif
   end

   // A stalled redirect has not resolved yet; reset overrides everything.
   assign w_stall = (w_ld_stall | w_br_stall) & ~reset;
   assign w_flush = pcsrcD & ~w_stall & ~reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_flush && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign stallF    = w_stall;
   assign stallD    = w_stall;
   assign flushE    = w_stall;
   assign flushD    = w_flush;
   assign fwdaE     = w_fa_e;
   assign fwdbE     = w_fb_e;
   assign fwdaD     = w_fa_d;
   assign fwdbD     = w_fb_d;
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule
